// File: rtl/hwpe_ctrl_reqrsp_initiator.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_reqrsp_initiator
// Function : Drives one HWPE job over a reqrsp control port: optional soft
//            clear, parameter push, trigger, JOBID read, STATUS poll, pull.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_reqrsp_initiator #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            NB_REGISTER = 16,
  parameter int unsigned            POLL_GAP    = 4,
  parameter int unsigned            POLL_MAX    = 1024,
  parameter int unsigned            CLR_WAIT    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          job_valid_i,
  output logic                          job_ready_o,
  input  logic                          job_clear_i,
  input  logic [$clog2(NB_REGISTER):0]  job_n_push_i,
  input  logic [$clog2(NB_REGISTER):0]  job_n_pull_i,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  output logic                          pull_valid_o,
  input  logic                          pull_ready_i,
  output logic [DATA_WIDTH-1:0]         pull_data_o,
  output logic                          cfg_q_valid_o,
  output logic                          cfg_q_write_o,
  output logic [ADDR_WIDTH-1:0]         cfg_q_addr_o,
  output logic [DATA_WIDTH-1:0]         cfg_q_data_o,
  input  logic                          cfg_q_ready_i,
  input  logic                          cfg_p_valid_i,
  input  logic [DATA_WIDTH-1:0]         cfg_p_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [15:0]                   job_id_o
);

  localparam int unsigned c_cnt_w    = $clog2(NB_REGISTER) + 1;
  localparam int unsigned c_poll_w   = $clog2(POLL_MAX + 1);
  localparam int unsigned c_wait_max = (POLL_GAP > CLR_WAIT) ? POLL_GAP : ((CLR_WAIT > 0) ? CLR_WAIT : 1);
  localparam int unsigned c_wait_w   = $clog2(c_wait_max + 1);
  localparam int unsigned c_clr_last = (CLR_WAIT > 0) ? CLR_WAIT - 1 : 0;
  localparam int unsigned c_gap_last = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  localparam logic [2:0] c_reg_trigger = 3'd0;
  localparam logic [2:0] c_reg_status  = 3'd1;
  localparam logic [2:0] c_reg_jobid   = 3'd2;
  localparam logic [2:0] c_reg_softclr = 3'd3;
  localparam logic [2:0] c_reg_push    = 3'd4;
  localparam logic [2:0] c_reg_pull    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_REQ, S_CLR_RSP, S_CLR_WAIT, S_PUSH, S_TRIG, S_JID_REQ, S_JID_RSP,
    S_POLL_REQ, S_POLL_RSP, S_POLL_WAIT, S_PULL_REQ, S_PULL_RSP, S_PULL_OUT, S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [c_cnt_w-1:0]      n_push_q, n_push_d;
  logic [c_cnt_w-1:0]      n_pull_q, n_pull_d;
  logic [c_poll_w-1:0]     poll_cnt_q, poll_cnt_d;
  logic [c_wait_w-1:0]     wait_q, wait_d;
  logic                    err_q, err_d;
  logic [15:0]             job_id_q, job_id_d;
  logic [DATA_WIDTH-1:0]   pull_data_q, pull_data_d;

  logic [c_cnt_w-1:0]      w_n_push, w_n_pull, w_cnt_inc;
  logic [2:0]              w_q_idx;
  logic                    w_q_valid;
  state_e                  w_after_clr;

  assign w_n_push    = (job_n_push_i > c_cnt_w'(NB_REGISTER)) ? c_cnt_w'(NB_REGISTER) : job_n_push_i;
  assign w_n_pull    = (job_n_pull_i > c_cnt_w'(NB_REGISTER)) ? c_cnt_w'(NB_REGISTER) : job_n_pull_i;
  assign w_cnt_inc   = cnt_q + c_cnt_w'(1);
  assign w_after_clr = (n_push_q == '0) ? S_TRIG : S_PUSH;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    n_push_d      = n_push_q;
    n_pull_d      = n_pull_q;
    poll_cnt_d    = poll_cnt_q;
    wait_d        = wait_q;
    err_d         = err_q;
    job_id_d      = job_id_q;
    pull_data_d   = pull_data_q;
    w_q_valid     = 1'b0;
    w_q_idx       = c_reg_trigger;
    cfg_q_write_o = 1'b0;
    cfg_q_data_o  = '0;
    push_ready_o  = 1'b0;
    pull_valid_o  = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    job_ready_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        job_ready_o = !rst_i;
        if (job_valid_i) begin
          n_push_d   = w_n_push;
          n_pull_d   = w_n_pull;
          cnt_d      = '0;
          poll_cnt_d = '0;
          wait_d     = '0;
          err_d      = 1'b0;
          state_d    = job_clear_i ? S_CLR_REQ : ((w_n_push == '0) ? S_TRIG : S_PUSH);
        end
      end
      // Soft clear is decoded by the slave on a read-type access.
      S_CLR_REQ: begin
        w_q_valid = 1'b1;
        w_q_idx   = c_reg_softclr;
        if (cfg_q_ready_i) state_d = S_CLR_RSP;
      end
      S_CLR_RSP: begin
        if (cfg_p_valid_i) begin
          wait_d  = '0;
          state_d = (CLR_WAIT == 0) ? w_after_clr : S_CLR_WAIT;
        end
      end
      S_CLR_WAIT: begin
        if (wait_q == c_wait_w'(c_clr_last)) state_d = w_after_clr;
        else                                  wait_d  = wait_q + c_wait_w'(1);
      end
      S_PUSH: begin
        w_q_valid     = push_valid_i;
        w_q_idx       = c_reg_push;
        cfg_q_write_o = 1'b1;
        cfg_q_data_o  = push_data_i;
        push_ready_o  = cfg_q_ready_i;
        if (push_valid_i && cfg_q_ready_i) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == n_push_q) begin
            cnt_d   = '0;
            state_d = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        w_q_valid     = 1'b1;
        w_q_idx       = c_reg_trigger;
        cfg_q_write_o = 1'b1;
        if (cfg_q_ready_i) state_d = S_JID_REQ;
      end
      S_JID_REQ: begin
        w_q_valid = 1'b1;
        w_q_idx   = c_reg_jobid;
        if (cfg_q_ready_i) state_d = S_JID_RSP;
      end
      S_JID_RSP: begin
        if (cfg_p_valid_i) begin
          job_id_d = cfg_p_data_i[15:0];
          state_d  = S_POLL_REQ;
        end
      end
      S_POLL_REQ: begin
        w_q_valid = 1'b1;
        w_q_idx   = c_reg_status;
        if (cfg_q_ready_i) state_d = S_POLL_RSP;
      end
      S_POLL_RSP: begin
        if (cfg_p_valid_i) begin
          if (!cfg_p_data_i[0]) begin
            cnt_d   = '0;
            state_d = (n_pull_q == '0) ? S_FIN : S_PULL_REQ;
          end else begin
            if (poll_cnt_q != c_poll_w'(POLL_MAX)) poll_cnt_d = poll_cnt_q + c_poll_w'(1);
            if (poll_cnt_q >= c_poll_w'(POLL_MAX - 1)) begin
              err_d   = 1'b1;
              state_d = S_FIN;
            end else begin
              wait_d  = '0;
              state_d = S_POLL_WAIT;
            end
          end
        end
      end
      S_POLL_WAIT: begin
        if (wait_q == c_wait_w'(c_gap_last)) state_d = S_POLL_REQ;
        else                                  wait_d  = wait_q + c_wait_w'(1);
      end
      S_PULL_REQ: begin
        w_q_valid = 1'b1;
        w_q_idx   = c_reg_pull;
        if (cfg_q_ready_i) state_d = S_PULL_RSP;
      end
      S_PULL_RSP: begin
        if (cfg_p_valid_i) begin
          pull_data_d = cfg_p_data_i;
          state_d     = S_PULL_OUT;
        end
      end
      S_PULL_OUT: begin
        pull_valid_o = 1'b1;
        if (pull_ready_i) begin
          cnt_d   = w_cnt_inc;
          state_d = (w_cnt_inc == n_pull_q) ? S_FIN : S_PULL_REQ;
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_q_valid_o = w_q_valid;
  // Address is forced to zero when no request is presented so idle outputs stay quiet.
  assign cfg_q_addr_o  = w_q_valid ? (BASE_ADDR + {{(ADDR_WIDTH-5){1'b0}}, w_q_idx, 2'b00}) : '0;
  assign busy_o        = (state_q != S_IDLE);
  assign job_id_o      = job_id_q;
  assign pull_data_o   = pull_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_push_q    <= '0;
      n_pull_q    <= '0;
      poll_cnt_q  <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      job_id_q    <= '0;
      pull_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_push_q    <= n_push_d;
      n_pull_q    <= n_pull_d;
      poll_cnt_q  <= poll_cnt_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      job_id_q    <= job_id_d;
      pull_data_q <= pull_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_reqrsp_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_ctrl_reqrsp_initiator
// Function : Scoreboard bench; directed jobs against a small HWPE slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_reqrsp_initiator;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          job_valid_i = 1'b0, job_clear_i = 1'b0;
  logic [4:0]    job_n_push_i = '0, job_n_pull_i = '0;
  logic          push_valid_i = 1'b0, pull_ready_i = 1'b1;
  logic [DW-1:0] push_data_i = '0;
  logic          cfg_q_ready_i = 1'b1, cfg_p_valid_i = 1'b0;
  logic [DW-1:0] cfg_p_data_i = '0;
  logic          job_ready_o, push_ready_o, pull_valid_o, cfg_q_valid_o, cfg_q_write_o;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] pull_data_o, cfg_q_data_o;
  logic [AW-1:0] cfg_q_addr_o;
  logic [15:0]   job_id_o;

  hwpe_ctrl_reqrsp_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0), .NB_REGISTER(16),
    .POLL_GAP(4), .POLL_MAX(8), .CLR_WAIT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_clear_i(job_clear_i),
    .job_n_push_i(job_n_push_i), .job_n_pull_i(job_n_pull_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_data_i(push_data_i),
    .pull_valid_o(pull_valid_o), .pull_ready_i(pull_ready_i), .pull_data_o(pull_data_o),
    .cfg_q_valid_o(cfg_q_valid_o), .cfg_q_write_o(cfg_q_write_o), .cfg_q_addr_o(cfg_q_addr_o),
    .cfg_q_data_o(cfg_q_data_o), .cfg_q_ready_i(cfg_q_ready_i),
    .cfg_p_valid_i(cfg_p_valid_i), .cfg_p_data_i(cfg_p_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .job_id_o(job_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; int gap; } req_t;
  typedef struct { logic err; int gap; } done_t;

  req_t          exp_req[$];
  logic [DW-1:0] exp_pull[$];
  done_t         exp_done[$];
  logic [DW-1:0] push_src[$];
  logic [DW-1:0] pull_src[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_rsp_cyc = -1000;
  int done_cnt = 0, push_hs_cnt = 0, stat_rsp_cnt = 0;
  int busy_left = 0, pull_block = 0;
  logic stall_en = 1'b0;
  logic [15:0] jid_val = 16'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input int g);
    req_t r;
    r.wr = 1'b1; r.addr = a; r.data = d; r.gap = g;
    exp_req.push_back(r);
  endtask

  task automatic exp_r(input logic [AW-1:0] a, input int g);
    req_t r;
    r.wr = 1'b0; r.addr = a; r.data = '0; r.gap = g;
    exp_req.push_back(r);
  endtask

  task automatic exp_fin(input logic e, input int g);
    done_t d;
    d.err = e; d.gap = g;
    exp_done.push_back(d);
  endtask

  // Slave model, push source and pull sink
  logic          rd_acc, push_acc;
  logic [AW-1:0] rd_addr;
  initial begin : env
    forever begin
      @(negedge clk_i);
      rd_acc   = !rst_i && cfg_q_valid_o && cfg_q_ready_i && !cfg_q_write_o;
      rd_addr  = cfg_q_addr_o;
      push_acc = !rst_i && push_valid_i && push_ready_o;
      @(posedge clk_i);
      #1;
      cfg_p_valid_i = 1'b0;
      cfg_p_data_i  = '0;
      if (rd_acc && !rst_i) begin
        cfg_p_valid_i = 1'b1;
        case (rd_addr)
          32'h4: begin
            stat_rsp_cnt++;
            if (busy_left > 0) begin busy_left--; cfg_p_data_i = 64'h1; end
          end
          32'h8:  cfg_p_data_i = {48'hFFFF_0000_0000, jid_val};
          32'hC:  cfg_p_data_i = 64'hDEAD;
          32'h14: cfg_p_data_i = (pull_src.size() > 0) ? pull_src.pop_front() : 64'hBAD;
          default: cfg_p_data_i = 64'hBAD;
        endcase
      end
      if (push_acc) begin
        push_hs_cnt++;
        if (push_src.size() > 0) void'(push_src.pop_front());
      end
      push_valid_i  = (push_src.size() > 0);
      push_data_i   = (push_src.size() > 0) ? push_src[0] : '0;
      cfg_q_ready_i = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pull_valid_o && pull_block > 0) begin
        pull_ready_i = 1'b0;
        pull_block--;
      end else begin
        pull_ready_i = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer
  logic          prev_stall = 1'b0, prev_pstall = 1'b0;
  logic          prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data, prev_pdata;
  initial begin : monitor
    req_t  r;
    done_t d;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall  = 1'b0;
        prev_pstall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("req_hold_valid", {63'h0, cfg_q_valid_o}, 64'h1);
          check("req_hold_write", {63'h0, cfg_q_write_o}, {63'h0, prev_wr});
          check("req_hold_addr", {32'h0, cfg_q_addr_o}, {32'h0, prev_addr});
          check("req_hold_data", cfg_q_data_o, prev_data);
        end
        if (cfg_q_valid_o) check("no_req_while_pull_valid", {63'h0, pull_valid_o}, 64'h0);
        if (cfg_q_valid_o && cfg_q_ready_i) begin
          if (exp_req.size() == 0) begin
            check("unexpected_req_addr", {32'h0, cfg_q_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            r = exp_req.pop_front();
            check("req_write", {63'h0, cfg_q_write_o}, {63'h0, r.wr});
            check("req_addr", {32'h0, cfg_q_addr_o}, {32'h0, r.addr});
            check("req_data", cfg_q_data_o, r.data);
            if (r.gap >= 0) check("req_gap_cycles", 64'(cyc - last_rsp_cyc), 64'(r.gap));
          end
        end
        prev_stall = cfg_q_valid_o && !cfg_q_ready_i;
        prev_wr = cfg_q_write_o; prev_addr = cfg_q_addr_o; prev_data = cfg_q_data_o;

        if (prev_pstall) begin
          check("pull_hold_valid", {63'h0, pull_valid_o}, 64'h1);
          check("pull_hold_data", pull_data_o, prev_pdata);
        end
        if (pull_valid_o && pull_ready_i) begin
          if (exp_pull.size() == 0) check("unexpected_pull", pull_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
          else                       check("pull_data", pull_data_o, exp_pull.pop_front());
        end
        prev_pstall = pull_valid_o && !pull_ready_i;
        prev_pdata  = pull_data_o;

        if (done_o) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            check("unexpected_done", 64'h1, 64'h0);
          end else begin
            d = exp_done.pop_front();
            check("done_err", {63'h0, err_o}, {63'h0, d.err});
            if (d.gap >= 0) check("done_gap_cycles", 64'(cyc - last_rsp_cyc), 64'(d.gap));
          end
        end else if (err_o) begin
          check("err_without_done", 64'h1, 64'h0);
        end
        if (cfg_p_valid_i) last_rsp_cyc = cyc;
      end
    end
  end

  task automatic run_job(input logic clr, input logic [4:0] np, input logic [4:0] nl);
    bit ok;
    @(posedge clk_i);
    #1;
    job_valid_i = 1'b1; job_clear_i = clr; job_n_push_i = np; job_n_pull_i = nl;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (job_ready_o) ok = 1;
    end
    if (!ok) check("job_accept_timeout", 64'h0, 64'h1);
    @(posedge clk_i);
    #1;
    job_valid_i = 1'b0; job_clear_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_i);
      if (done_cnt >= target) ok = 1;
    end
    if (!ok) check("done_timeout", 64'(done_cnt), 64'(target));
    repeat (3) @(negedge clk_i);
    check("req_queue_drained", 64'(exp_req.size()), 64'h0);
    check("pull_queue_drained", 64'(exp_pull.size()), 64'h0);
    check("done_queue_drained", 64'(exp_done.size()), 64'h0);
    check("idle_ready", {63'h0, job_ready_o}, 64'h1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_job_ready"}, {63'h0, job_ready_o}, 64'h0);
    check({tag, "_q_valid"}, {63'h0, cfg_q_valid_o}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy_o}, 64'h0);
    check({tag, "_done"}, {63'h0, done_o}, 64'h0);
    check({tag, "_err"}, {63'h0, err_o}, 64'h0);
    check({tag, "_push_ready"}, {63'h0, push_ready_o}, 64'h0);
    check({tag, "_pull_valid"}, {63'h0, pull_valid_o}, 64'h0);
    check({tag, "_job_id"}, {48'h0, job_id_o}, 64'h0);
  endtask

  initial begin : main
    int jobs;
    int hs0;
    bit ok;
    jobs = 0;
    #2 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 check_quiet("reset");
    @(negedge clk_i) rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_job_ready", {63'h0, job_ready_o}, 64'h1);

    // Job 1: no clear, three pushes, two busy polls, nothing to pull
    push_src = '{64'hA, 64'hB, 64'hC};
    busy_left = 2; jid_val = 16'h00A1;
    exp_w(32'h10, 64'hA, -1); exp_w(32'h10, 64'hB, -1); exp_w(32'h10, 64'hC, -1);
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1);
    exp_r(32'h4, 1); exp_r(32'h4, 5); exp_r(32'h4, 5);
    exp_fin(1'b0, 1);
    run_job(1'b0, 5'd3, 5'd0);
    wait_done(++jobs);
    check("job1_id", {48'h0, job_id_o}, 64'h00A1);

    // Job 2: soft clear first, then CLR_WAIT idle cycles before the push
    push_src = '{64'h1234};
    busy_left = 0; jid_val = 16'h00B2;
    exp_r(32'hC, -1); exp_w(32'h10, 64'h1234, 5);
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1); exp_r(32'h4, 1);
    exp_fin(1'b0, 1);
    run_job(1'b1, 5'd1, 5'd0);
    wait_done(++jobs);
    check("job2_id", {48'h0, job_id_o}, 64'h00B2);

    // Job 3: random request stalls, 16 pushes (requested 20, clamped)
    stall_en = 1'b1; busy_left = 1; jid_val = 16'h0C03;
    for (int i = 0; i < 16; i++) begin
      push_src.push_back(64'h100 + 64'(i));
      exp_w(32'h10, 64'h100 + 64'(i), -1);
    end
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1); exp_r(32'h4, -1); exp_r(32'h4, -1);
    exp_r(32'h14, -1); pull_src = '{64'h5555}; exp_pull.push_back(64'h5555);
    exp_fin(1'b0, -1);
    hs0 = push_hs_cnt;
    run_job(1'b0, 5'd20, 5'd1);
    wait_done(++jobs);
    stall_en = 1'b0;
    check("job3_push_handshakes", 64'(push_hs_cnt - hs0), 64'd16);
    check("job3_push_src_empty", 64'(push_src.size()), 64'h0);

    // Job 4: two pulls, first word back-pressured for five cycles
    busy_left = 0; jid_val = 16'h0D04; pull_block = 5;
    pull_src = '{64'h1111, 64'h2222};
    exp_pull.push_back(64'h1111); exp_pull.push_back(64'h2222);
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1); exp_r(32'h4, 1);
    exp_r(32'h14, 1); exp_r(32'h14, -1);
    exp_fin(1'b0, -1);
    run_job(1'b0, 5'd0, 5'd2);
    wait_done(++jobs);
    check("job4_pull_block_used", 64'(pull_block), 64'h0);

    // Job 5: slave never goes idle, POLL_MAX busy responses end the job in error
    busy_left = 100; jid_val = 16'h0E05;
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1); exp_r(32'h4, 1);
    for (int i = 0; i < 7; i++) exp_r(32'h4, 5);
    exp_fin(1'b1, 1);
    hs0 = stat_rsp_cnt;
    run_job(1'b0, 5'd0, 5'd2);
    wait_done(++jobs);
    check("job5_status_reads", 64'(stat_rsp_cnt - hs0), 64'd8);

    // Job 6: reset while waiting between polls, then a clean job
    busy_left = 100; jid_val = 16'h0F06;
    push_src = '{64'h77};
    exp_w(32'h10, 64'h77, -1); exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1);
    exp_r(32'h4, 1); exp_r(32'h4, 5); exp_r(32'h4, 5);
    exp_fin(1'b1, -1);
    hs0 = stat_rsp_cnt;
    run_job(1'b0, 5'd1, 5'd0);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk_i);
      if (stat_rsp_cnt - hs0 >= 2) ok = 1;
    end
    if (!ok) check("job6_poll_timeout", 64'(stat_rsp_cnt - hs0), 64'd2);
    @(negedge clk_i);
    check("job6_busy_before_reset", {63'h0, busy_o}, 64'h1);
    #2 rst_i = 1'b1;
    #1 check_quiet("midjob_reset");
    repeat (2) @(posedge clk_i);
    check("job6_leftover_reqs", 64'(exp_req.size()), 64'h1);
    exp_req.delete(); exp_done.delete();
    @(negedge clk_i) rst_i = 1'b0;
    @(negedge clk_i);
    check("job6_ready_after_reset", {63'h0, job_ready_o}, 64'h1);
    done_cnt = 0; jobs = 0;
    busy_left = 0; jid_val = 16'h0A07;
    pull_src = '{64'h3333}; exp_pull.push_back(64'h3333);
    exp_w(32'h0, 64'h0, -1); exp_r(32'h8, -1); exp_r(32'h4, 1); exp_r(32'h14, 1);
    exp_fin(1'b0, -1);
    run_job(1'b0, 5'd0, 5'd1);
    wait_done(++jobs);
    check("job7_id", {48'h0, job_id_o}, 64'h0A07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
